// File: rtl/display_framebuffer_dbuf_pkg.sv
// Shared types and width helpers for the double-buffered display framebuffer.
package display_framebuffer_dbuf_pkg;

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} fb_wstate_t;

  function automatic int pixel_w(input int bitwidth);
    return 3 * bitwidth;
  endfunction

  // Keeps single-entry dimensions at one address bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display_framebuffer_dbuf_if.sv
// Host-side pixel write stream (valid/ready with start-of-frame marker).
interface display_framebuffer_dbuf_if
  import display_framebuffer_dbuf_pkg::*;
#(
  parameter int BITWIDTH = 8
) ();
  localparam int PW = pixel_w(BITWIDTH);

  logic          wr_valid;
  logic          wr_ready;
  logic          wr_sof;
  logic [PW-1:0] wr_data;

  modport master (output wr_valid, output wr_sof, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_sof, input wr_data, output wr_ready);
endinterface

// File: rtl/display_framebuffer_bank.sv
// Simple dual-port RAM, one write port and one registered read port.
module display_framebuffer_bank #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the read register is cleared; array contents survive reset.
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end
endmodule

// File: rtl/display_framebuffer_dbuf.sv
// Double-buffered pixel store feeding the display driver; swaps only on frame_complete.
// Optional build macro DISPLAY_FB_TEST_PATTERN_EN adds a generated test-pattern source.
module display_framebuffer_dbuf
  import display_framebuffer_dbuf_pkg::*;
#(
  parameter  int SEGMENTS = 1,
  parameter  int ROWS     = 8,
  parameter  int COLUMNS  = 32,
  parameter  int BITWIDTH = 8,
  localparam int PW       = pixel_w(BITWIDTH),
  localparam int RW       = addr_w(ROWS),
  localparam int CW       = addr_w(COLUMNS),
  localparam int SW       = addr_w(SEGMENTS),
  localparam int AW       = 1 + RW + CW
) (
  input  logic                     clk,
  input  logic                     rst,
  display_framebuffer_dbuf_if.slave wr,
  input  logic [RW-1:0]            row,
  input  logic [CW-1:0]            column,
  input  logic                     frame_complete,
`ifdef DISPLAY_FB_TEST_PATTERN_EN
  input  logic                     test_pattern,
`endif
  output logic [PW*SEGMENTS-1:0]   pixel,
  output logic                     front_sel,
  output logic                     swap_done
);

  fb_wstate_t    state_q, state_d;
  logic [SW-1:0] wseg_q, seg_at, seg_n;
  logic [RW-1:0] wrow_q, row_at, row_n;
  logic [CW-1:0] wcol_q, col_at, col_n;
  logic          xfer, last_col, last_row, last_seg, last_px, swap;

  // A sof beat overrides the counters so the beat itself lands at (0,0,0).
  assign seg_at = wr.wr_sof ? '0 : wseg_q;
  assign row_at = wr.wr_sof ? '0 : wrow_q;
  assign col_at = wr.wr_sof ? '0 : wcol_q;

  assign last_col = (col_at == CW'(COLUMNS - 1));
  assign last_row = (row_at == RW'(ROWS - 1));
  assign last_seg = (seg_at == SW'(SEGMENTS - 1));
  assign last_px  = last_col && last_row && last_seg;

  assign wr.wr_ready = (state_q == FILL);
  assign xfer        = wr.wr_valid && wr.wr_ready;
  assign swap        = (state_q == FULL) && frame_complete;

  always_comb begin
    seg_n = seg_at;
    row_n = row_at;
    col_n = col_at + 1'b1;
    if (last_col) begin
      col_n = '0;
      row_n = row_at + 1'b1;
      if (last_row) begin
        row_n = '0;
        seg_n = last_seg ? '0 : seg_at + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (xfer && last_px) state_d = FULL;
      FULL:    if (frame_complete)  state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      wseg_q    <= '0;
      wrow_q    <= '0;
      wcol_q    <= '0;
      front_sel <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      swap_done <= swap;
      if (swap) front_sel <= ~front_sel;
      if (xfer) begin
        wseg_q <= seg_n;
        wrow_q <= row_n;
        wcol_q <= col_n;
      end
    end
  end

  logic [SEGMENTS-1:0][PW-1:0] rdata;
  logic [AW-1:0]               waddr, raddr;

  // Bank select is the address MSB; writes always hit the back bank.
  assign waddr = {~front_sel, row_at, col_at};
  assign raddr = {front_sel, row, column};

  for (genvar s = 0; s < SEGMENTS; s++) begin : g_seg
    display_framebuffer_bank #(.DATA_W(PW), .ADDR_W(AW)) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (xfer && (seg_at == SW'(s))),
      .waddr (waddr),
      .wdata (wr.wr_data),
      .raddr (raddr),
      .rdata (rdata[s])
    );
  end

`ifdef DISPLAY_FB_TEST_PATTERN_EN
  logic                        tp_q;
  logic [RW-1:0]               row_q;
  logic [CW-1:0]               col_q;
  logic [SEGMENTS-1:0][PW-1:0] pix;

  always_ff @(posedge clk) begin
    if (rst) begin
      tp_q  <= 1'b0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      tp_q  <= test_pattern;
      row_q <= row;
      col_q <= column;
    end
  end

  for (genvar s = 0; s < SEGMENTS; s++) begin : g_tp
    assign pix[s] = tp_q ? {BITWIDTH'(col_q), BITWIDTH'(row_q), BITWIDTH'(s)} : rdata[s];
  end

  assign pixel = pix;
`else
  assign pixel = rdata;
`endif

endmodule

// File: tb/tb_display_framebuffer_dbuf.sv
// Directed bench for display_framebuffer_dbuf: 2 segments x 2 rows x 4 columns, 2-bit channels.
module tb_display_framebuffer_dbuf;
  localparam int SEG = 2, ROWS = 2, COLS = 4, BW = 2, PW = 3 * BW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [0:0]       row = '0;
  logic [1:0]       column = '0;
  logic             frame_complete = 1'b0;
  logic [PW*SEG-1:0] pixel;
  logic             front_sel, swap_done;
`ifdef DISPLAY_FB_TEST_PATTERN_EN
  logic             test_pattern = 1'b0;
`endif

  int checks = 0;
  int fails  = 0;

  display_framebuffer_dbuf_if #(.BITWIDTH(BW)) wr_if ();

  display_framebuffer_dbuf #(.SEGMENTS(SEG), .ROWS(ROWS), .COLUMNS(COLS), .BITWIDTH(BW)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr             (wr_if),
    .row            (row),
    .column         (column),
    .frame_complete (frame_complete),
`ifdef DISPLAY_FB_TEST_PATTERN_EN
    .test_pattern   (test_pattern),
`endif
    .pixel          (pixel),
    .front_sel      (front_sel),
    .swap_done      (swap_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_sof   = 1'b0;
    wr_if.wr_data  = '0;
    frame_complete = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [PW-1:0] d, input logic sof);
    int n = 0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = d;
    wr_if.wr_sof   = sof;
    while (wr_if.wr_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) begin
      checks++;
      fails++;
      $display("FAIL push_timeout: wr_ready stayed %b, required 1 within 20 cycles", wr_if.wr_ready);
    end
    tick();
    wr_if.wr_valid = 1'b0;
    wr_if.wr_sof   = 1'b0;
  endtask

  task automatic fill_frame();
    for (int i = 0; i < 16; i++) push(PW'(i), i == 0);
  endtask

  task automatic pulse_fc();
    frame_complete = 1'b1;
    tick();
    frame_complete = 1'b0;
  endtask

  task automatic read_px(input logic [0:0] r, input logic [1:0] c);
    row = r;
    column = c;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pixel !== 12'd0) begin fails++; $display("FAIL rst_pixel: got %h required 000", pixel); end
    checks++; if (front_sel !== 1'b0) begin fails++; $display("FAIL rst_front: got %b required 0", front_sel); end
    checks++; if (swap_done !== 1'b0) begin fails++; $display("FAIL rst_swap_done: got %b required 0", swap_done); end
    checks++; if (wr_if.wr_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b required 1", wr_if.wr_ready); end
  endtask

  task automatic test_fill_swap();
    do_reset();
    fill_frame();
    checks++; if (wr_if.wr_ready !== 1'b0) begin fails++; $display("FAIL fill_ready_low: got %b required 0", wr_if.wr_ready); end
    checks++; if (front_sel !== 1'b0) begin fails++; $display("FAIL fill_front_hold: got %b required 0", front_sel); end
    pulse_fc();
    checks++; if (front_sel !== 1'b1) begin fails++; $display("FAIL swap_front: got %b required 1", front_sel); end
    checks++; if (swap_done !== 1'b1) begin fails++; $display("FAIL swap_done_pulse: got %b required 1", swap_done); end
    checks++; if (wr_if.wr_ready !== 1'b1) begin fails++; $display("FAIL swap_ready: got %b required 1", wr_if.wr_ready); end
    tick();
    checks++; if (swap_done !== 1'b0) begin fails++; $display("FAIL swap_done_width: got %b required 0", swap_done); end
    read_px(1'b1, 2'd2);
    checks++; if (pixel !== {6'd14, 6'd6}) begin fails++; $display("FAIL read_r1c2: got %h required %h", pixel, {6'd14, 6'd6}); end
    read_px(1'b0, 2'd0);
    checks++; if (pixel !== {6'd8, 6'd0}) begin fails++; $display("FAIL read_r0c0: got %h required %h", pixel, {6'd8, 6'd0}); end
  endtask

  task automatic test_backpressure();
    do_reset();
    fill_frame();
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = 6'd63;
    wr_if.wr_sof   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (wr_if.wr_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_%0d: got %b required 0", i, wr_if.wr_ready); end
    end
    pulse_fc();
    checks++; if (wr_if.wr_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_after_swap: got %b required 1", wr_if.wr_ready); end
    tick();
    wr_if.wr_valid = 1'b0;
    wr_if.wr_sof   = 1'b0;
    read_px(1'b0, 2'd0);
    checks++; if (pixel !== {6'd8, 6'd0}) begin fails++; $display("FAIL bp_no_stall_write: got %h required %h", pixel, {6'd8, 6'd0}); end
    for (int i = 1; i < 16; i++) push(PW'(i), 1'b0);
    checks++; if (wr_if.wr_ready !== 1'b0) begin fails++; $display("FAIL bp_second_full: got %b required 0", wr_if.wr_ready); end
    pulse_fc();
    checks++; if (front_sel !== 1'b0) begin fails++; $display("FAIL bp_front_back: got %b required 0", front_sel); end
    read_px(1'b0, 2'd0);
    checks++; if (pixel !== {6'd8, 6'd63}) begin fails++; $display("FAIL bp_write_bank0: got %h required %h", pixel, {6'd8, 6'd63}); end
  endtask

  task automatic test_coincident();
    do_reset();
    for (int i = 0; i < 15; i++) push(PW'(i), i == 0);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = 6'd15;
    frame_complete = 1'b1;
    tick();
    wr_if.wr_valid = 1'b0;
    frame_complete = 1'b0;
    checks++; if (front_sel !== 1'b0) begin fails++; $display("FAIL coinc_front: got %b required 0", front_sel); end
    checks++; if (wr_if.wr_ready !== 1'b0) begin fails++; $display("FAIL coinc_pending: got %b required 0", wr_if.wr_ready); end
    tick();
    checks++; if (swap_done !== 1'b0) begin fails++; $display("FAIL coinc_no_swap_done: got %b required 0", swap_done); end
    pulse_fc();
    checks++; if (front_sel !== 1'b1) begin fails++; $display("FAIL coinc_late_swap: got %b required 1", front_sel); end
    checks++; if (swap_done !== 1'b1) begin fails++; $display("FAIL coinc_late_done: got %b required 1", swap_done); end
  endtask

  task automatic test_resync();
    do_reset();
    for (int i = 0; i < 5; i++) push(PW'(i), i == 0);
    push(6'd9, 1'b1);
    for (int i = 1; i < 16; i++) push(PW'(i), 1'b0);
    checks++; if (wr_if.wr_ready !== 1'b0) begin fails++; $display("FAIL resync_full: got %b required 0", wr_if.wr_ready); end
    pulse_fc();
    checks++; if (front_sel !== 1'b1) begin fails++; $display("FAIL resync_front: got %b required 1", front_sel); end
    read_px(1'b0, 2'd0);
    checks++; if (pixel !== {6'd8, 6'd9}) begin fails++; $display("FAIL resync_origin: got %h required %h", pixel, {6'd8, 6'd9}); end
    read_px(1'b1, 2'd2);
    checks++; if (pixel !== {6'd14, 6'd6}) begin fails++; $display("FAIL resync_r1c2: got %h required %h", pixel, {6'd14, 6'd6}); end
  endtask

  task automatic test_reset_midfill();
    do_reset();
    fill_frame();
    pulse_fc();
    for (int i = 0; i < 7; i++) push(PW'(40 + i), i == 0);
    read_px(1'b1, 2'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (front_sel !== 1'b0) begin fails++; $display("FAIL mid_rst_front: got %b required 0", front_sel); end
    checks++; if (wr_if.wr_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_ready: got %b required 1", wr_if.wr_ready); end
    checks++; if (swap_done !== 1'b0) begin fails++; $display("FAIL mid_rst_swap_done: got %b required 0", swap_done); end
    checks++; if (pixel !== 12'd0) begin fails++; $display("FAIL mid_rst_pixel: got %h required 000", pixel); end
    for (int i = 0; i < 15; i++) push(PW'(i), 1'b0);
    checks++; if (wr_if.wr_ready !== 1'b1) begin fails++; $display("FAIL mid_partial_ready: got %b required 1", wr_if.wr_ready); end
    pulse_fc();
    checks++; if (front_sel !== 1'b0) begin fails++; $display("FAIL mid_partial_no_swap: got %b required 0", front_sel); end
    push(6'd15, 1'b0);
    checks++; if (wr_if.wr_ready !== 1'b0) begin fails++; $display("FAIL mid_full: got %b required 0", wr_if.wr_ready); end
    pulse_fc();
    checks++; if (front_sel !== 1'b1) begin fails++; $display("FAIL mid_swap: got %b required 1", front_sel); end
    read_px(1'b0, 2'd0);
    checks++; if (pixel !== {6'd8, 6'd0}) begin fails++; $display("FAIL mid_origin: got %h required %h", pixel, {6'd8, 6'd0}); end
  endtask

  task automatic test_idle_fc();
    do_reset();
    pulse_fc();
    checks++; if (front_sel !== 1'b0) begin fails++; $display("FAIL idle_front0: got %b required 0", front_sel); end
    checks++; if (swap_done !== 1'b0) begin fails++; $display("FAIL idle_done0: got %b required 0", swap_done); end
    fill_frame();
    pulse_fc();
    tick();
    pulse_fc();
    checks++; if (front_sel !== 1'b1) begin fails++; $display("FAIL idle_front1: got %b required 1", front_sel); end
    checks++; if (swap_done !== 1'b0) begin fails++; $display("FAIL idle_done1: got %b required 0", swap_done); end
  endtask

`ifdef DISPLAY_FB_TEST_PATTERN_EN
  task automatic test_pattern_gen();
    test_pattern = 1'b1;
    read_px(1'b1, 2'd2);
    test_pattern = 1'b0;
    checks++; if (pixel !== {2'd2, 2'd1, 2'd1, 2'd2, 2'd1, 2'd0}) begin fails++; $display("FAIL tp_pixel: got %h required %h", pixel, {2'd2, 2'd1, 2'd1, 2'd2, 2'd1, 2'd0}); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_swap();
    test_backpressure();
    test_coincident();
    test_resync();
    test_reset_midfill();
    test_idle_fc();
`ifdef DISPLAY_FB_TEST_PATTERN_EN
    test_pattern_gen();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/display_framebuffer_dbuf.md
Name: display_framebuffer_dbuf

Overview:
Double-buffered pixel store that sits directly upstream of the pulse-width display driver. A host streams frames into the back buffer through a valid/ready write port. The driver reads the front buffer by row/column with one cycle of latency, so the driver's load_delay is 1. The buffers swap only on the driver's frame_complete pulse, so a displayed frame never tears.

Parameters:
segments, 1, number of vertically stacked panel segments driven in parallel
rows, 8, addressable rows per segment
columns, 32, pixels per row
bitwidth, 8, bits per colour channel; one pixel is 3*bitwidth bits as {r,g,b}

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
wr_valid  in  1  host pixel valid
wr_ready  out  1  block can accept a pixel this cycle
wr_sof  in  1  with wr_valid: this pixel is the first of a frame; resynchronises the write counters
wr_data  in  3*bitwidth  one pixel for one segment
row  in  $clog2(rows)  read row from the driver
column  in  $clog2(columns)  read column from the driver
frame_complete  in  1  driver pulse marking the end of a displayed frame
pixel  out  3*bitwidth*segments  front-buffer pixel for every segment; segment 0 in the LSBs
front_sel  out  1  index of the buffer currently displayed
swap_done  out  1  one-cycle pulse, the cycle after a swap takes effect

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Storage: two banks × segments × rows × columns words of 3*bitwidth bits each. A write goes to bank !front_sel; a read comes from bank front_sel.
- Write order: column fastest, then row, then segment. Counters wcol, wrow, wseg.
- A transfer occurs when wr_valid && wr_ready.
- On a transfer with wr_sof=1, the pixel is written at (0,0,0) and the counters advance from there. Any partial frame is discarded; no error is raised.
- After the transfer at (seg=segments-1, row=rows-1, col=columns-1):
  - counters wrap to 0;
  - pending is set on the next edge.
- wr_ready = !pending. While pending, the host stalls.
- Swap: when frame_complete=1 && pending=1:
  - front_sel toggles at that edge;
  - pending clears at that edge;
  - swap_done=1 for the following cycle only.
- frame_complete with pending=0 is ignored; front_sel holds, so the last complete frame is redisplayed.
- Simultaneous events: if the last pixel of a frame is accepted in the same cycle as frame_complete, pending is not yet set. No swap occurs; the swap waits for the next frame_complete.
- Read latency: pixel reflects (row, column, front_sel) sampled at the previous edge, exactly 1 cycle. The read is unaffected by writes, because writes always target the other bank.
- A swap changes pixel source from the cycle after the swap edge.
- Reset values, asserted at any time including mid-frame:
  - outputs: pixel=0, front_sel=0, swap_done=0, wr_ready=1 (the cycle after reset);
  - internal state: pending=0, counters=0.
  - Memory contents are not cleared.
- Width rules: counters are $clog2 width and wrap by explicit compare to rows-1 / columns-1 / segments-1, so non-power-of-2 sizes are supported. Addresses beyond rows/columns on the read port are don't-care.
- State machine (write side): FILL (pending=0) -> FULL (pending=1) on the last-pixel transfer. FULL -> FILL on a swap.

Optional Feature:
DISPLAY_FB_TEST_PATTERN_EN
- Defined:
  - adds input test_pattern (1 bit);
  - while test_pattern=1, pixel is generated rather than read: for each segment, r = column low bits, g = row low bits, b = segment index, each zero-extended or truncated to bitwidth;
  - the same 1-cycle latency applies;
  - the write path and swap logic are unaffected.
- Undefined: no port, no logic, and pixel always comes from memory.

Decomposition:
- Shared package holds:
  - pixel width constant PIXEL_W = 3*bitwidth, as a function or localparam helper;
  - address width helpers;
  - fb_wstate_t enum {FILL, FULL}.
- One sub-module: display_framebuffer_bank. It is a simple dual-port RAM with a registered read, one write port and one read port, instantiated per segment. The bank-select bit is folded into its address MSB.

Test Plan:
- Bench configuration for all scenarios: segments=2, rows=2, columns=4, bitwidth=2.
- Fill and swap: reset, stream 16 pixels with data = index (seg*8+row*4+col) and wr_sof on the first; wr_ready falls the cycle after the 16th; pulse frame_complete. Expect swap_done one cycle later and front_sel=1. Reading row=1, col=2 gives pixel={6'd14,6'd6} one cycle later.
- Backpressure: while pending, hold wr_valid=1 with data 63. Expect no write and wr_ready=0. After the swap, wr_ready=1 and the write lands in bank 0.
- Coincident last-pixel and frame_complete: front_sel stays at its old value. The next frame_complete swaps it.
- Resync: write 5 pixels, then one with wr_sof=1 and data 9, plus 15 more. After the swap, (seg0,row0,col0) reads 9.
- Reset mid-fill: assert rst after 7 pixels. Expect front_sel=0, wr_ready=1 and swap_done=0. A full new frame is then required before any swap.
- Idle frame_complete: pulse frame_complete with pending=0. Expect no swap_done and front_sel unchanged.
